// File: rtl/aes_dec_pkg.sv
// ============================================================================
//  Module      : aes_dec_pkg
//  Description : Shared constants and types for the AES decryption round-key
//                path (round-key store, sequencing).
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package aes_dec_pkg;

    localparam int NR_128 = 10;
    localparam int RK_W   = 128;

    typedef logic [0:RK_W-1] rkey_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/rkey_table.sv
// ============================================================================
//  Module      : rkey_table
//  Description : (NR+1) x 128 round-key storage, one write port and one
//                registered read port.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rkey_table
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_128,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  rkey_t         wr_data_i,
    input  logic          rd_en_i,
    input  logic [IW-1:0] rd_idx_i,
    output rkey_t         rd_data_o
);

    localparam logic [IW-1:0] c_IDX_LAST = IW'(NR);

    // Storage carries no reset so it can map onto a RAM macro.
    rkey_t mem_q [0:NR];
    rkey_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_idx_i <= c_IDX_LAST)) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/rkey_store_ctrl.sv
// ============================================================================
//  Module      : rkey_store_ctrl
//  Description : Hands new keys to the key expander, captures the round-key
//                stream and replays it in reverse order for decryption.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rkey_store_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_128,
    parameter int IW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:RK_W-1] key_in,
    input  logic            key_in_vld,
    output logic            key_in_rdy,
    output logic [0:RK_W-1] kx_kt,
    output logic            kx_kt_vld,
    input  logic            kx_kt_rdy,
    input  logic [0:RK_W-1] kx_rkey,
    input  logic            kx_rkey_vld,
    input  logic            kx_rkey_last,
    output logic            key_ok,
    input  logic            rd_start,
    input  logic            rd_next,
    output logic [0:RK_W-1] rk_out,
    output logic [0:IW-1]   rk_idx,
    output logic            rk_out_vld,
    output logic            rk_out_last,
    output logic            kx_err
);

    localparam logic [IW-1:0] c_IDX_LAST = IW'(NR);

    ld_state_t     state_q,   state_d;
    logic [IW-1:0] wr_ptr_q,  wr_ptr_d;
    logic          key_ok_q,  key_ok_d;
    logic          kx_err_q,  kx_err_d;
    logic          rep_act_q, rep_act_d;
    logic [IW-1:0] rk_idx_q,  rk_idx_d;

    logic          accept;
    logic          tbl_we;
    logic [IW-1:0] tbl_widx;
    logic          tbl_re;
    logic [IW-1:0] tbl_ridx;
    rkey_t         tbl_rdata;

    assign key_in_rdy = (state_q != LOAD) && !rep_act_q && kx_kt_rdy;
    assign accept     = key_in_vld && key_in_rdy;
    assign kx_kt      = key_in;
    assign kx_kt_vld  = accept;

    // Load side: the expander echoes the cipher key as round 0 in the
    // accept cycle, then streams rounds 1..NR back-to-back.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        key_ok_d = key_ok_q;
        kx_err_d = kx_err_q;
        tbl_we   = 1'b0;
        tbl_widx = wr_ptr_q;
        if (accept) begin
            tbl_we   = 1'b1;
            tbl_widx = '0;
            wr_ptr_d = IW'(1);
            key_ok_d = 1'b0;
            state_d  = LOAD;
        end else if (state_q == LOAD) begin
            if (!kx_rkey_vld) begin
                kx_err_d = 1'b1;
                key_ok_d = 1'b0;
                state_d  = EMPTY;
            end else begin
                tbl_we = 1'b1;
                if (kx_rkey_last) begin
                    if (wr_ptr_q == c_IDX_LAST) begin
                        key_ok_d = 1'b1;
                        state_d  = READY;
                    end else begin
                        kx_err_d = 1'b1;
                        key_ok_d = 1'b0;
                        state_d  = EMPTY;
                    end
                end else if (wr_ptr_q == c_IDX_LAST) begin
                    // Table full but the stream claims more rounds.
                    kx_err_d = 1'b1;
                    key_ok_d = 1'b0;
                    state_d  = EMPTY;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
        end
    end

    // Replay side: rd_start restarts at round NR and wins over rd_next.
    always_comb begin
        rep_act_d = rep_act_q;
        rk_idx_d  = rk_idx_q;
        tbl_re    = 1'b0;
        tbl_ridx  = rk_idx_q;
        if (rd_start && key_ok_q) begin
            rep_act_d = 1'b1;
            rk_idx_d  = c_IDX_LAST;
            tbl_re    = 1'b1;
            tbl_ridx  = c_IDX_LAST;
        end else if (rd_next && rep_act_q) begin
            if (rk_idx_q != '0) begin
                rk_idx_d = rk_idx_q - 1'b1;
                tbl_re   = 1'b1;
                tbl_ridx = rk_idx_q - 1'b1;
            end else begin
                rep_act_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            key_ok_q  <= 1'b0;
            kx_err_q  <= 1'b0;
            rep_act_q <= 1'b0;
            rk_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            key_ok_q  <= key_ok_d;
            kx_err_q  <= kx_err_d;
            rep_act_q <= rep_act_d;
            rk_idx_q  <= rk_idx_d;
        end
    end

    rkey_table #(
        .NR (NR),
        .IW (IW)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (tbl_we),
        .wr_idx_i  (tbl_widx),
        .wr_data_i (kx_rkey),
        .rd_en_i   (tbl_re),
        .rd_idx_i  (tbl_ridx),
        .rd_data_o (tbl_rdata)
    );

    assign rk_out      = tbl_rdata;
    assign rk_idx      = rk_idx_q;
    assign rk_out_vld  = rep_act_q;
    assign rk_out_last = rep_act_q && (rk_idx_q == '0);
    assign key_ok      = key_ok_q;
    assign kx_err      = kx_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rkey_store_ctrl.sv
// ============================================================================
//  Module      : tb_rkey_store_ctrl
//  Description : Bench for rkey_store_ctrl with an AES-128 key-expander model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rkey_store_ctrl;
    import aes_dec_pkg::*;

    localparam int NR = 10;
    localparam int IW = 4;

    localparam rkey_t K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam rkey_t R1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam rkey_t R10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam rkey_t K_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam rkey_t R10_B = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    rkey_t         key_in = '0;
    logic          key_in_vld = 1'b0;
    logic          key_in_rdy;
    rkey_t         kx_kt;
    logic          kx_kt_vld;
    logic          kx_kt_rdy;
    rkey_t         kx_rkey;
    logic          kx_rkey_vld;
    logic          kx_rkey_last;
    logic          key_ok;
    logic          rd_start = 1'b0;
    logic          rd_next = 1'b0;
    rkey_t         rk_out;
    logic [0:IW-1] rk_idx;
    logic          rk_out_vld;
    logic          rk_out_last;
    logic          kx_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rkey_store_ctrl #(.NR(NR), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_in_vld   (key_in_vld),
        .key_in_rdy   (key_in_rdy),
        .kx_kt        (kx_kt),
        .kx_kt_vld    (kx_kt_vld),
        .kx_kt_rdy    (kx_kt_rdy),
        .kx_rkey      (kx_rkey),
        .kx_rkey_vld  (kx_rkey_vld),
        .kx_rkey_last (kx_rkey_last),
        .key_ok       (key_ok),
        .rd_start     (rd_start),
        .rd_next      (rd_next),
        .rk_out       (rk_out),
        .rk_idx       (rk_idx),
        .rk_out_vld   (rk_out_vld),
        .rk_out_last  (rk_out_last),
        .kx_err       (kx_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AES-128 key expansion (FIPS-197) ----------------
    logic [7:0] sbox [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic rkey_t expand_rk(input rkey_t k, input int r);
        logic [31:0]  w [0:43];
        logic [127:0] kk;
        logic [31:0]  t;
        logic [7:0]   rc;
        kk = k;
        for (int i = 0; i < 4; i++) w[i] = kk[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- expander stand-in ----------------
    // mode 0: clean stream; 1: valid drops after 5 keys; 2: last at round 7
    logic  exp_busy  = 1'b0;
    int    exp_round = 0;
    int    exp_mode  = 0;
    rkey_t exp_sched [0:NR];

    assign kx_kt_rdy = !exp_busy;

    always @(posedge clk) begin
        if (rst) begin
            exp_busy <= 1'b0;
        end else if (!exp_busy && kx_kt_vld) begin
            for (int r = 0; r <= NR; r++) exp_sched[r] <= expand_rk(kx_kt, r);
            exp_busy  <= 1'b1;
            exp_round <= 1;
        end else if (exp_busy) begin
            if (exp_round == NR || (exp_mode == 2 && exp_round == 7) || (exp_mode == 1 && exp_round == 5))
                exp_busy <= 1'b0;
            else
                exp_round <= exp_round + 1;
        end
    end

    always_comb begin
        kx_rkey      = key_in;
        kx_rkey_vld  = kx_kt_vld;
        kx_rkey_last = 1'b0;
        if (exp_busy) begin
            kx_rkey      = exp_sched[exp_round];
            kx_rkey_vld  = !(exp_mode == 1 && exp_round == 5);
            kx_rkey_last = (exp_round == NR) || (exp_mode == 2 && exp_round == 7);
        end
    end

    // ---------------- behavioural reference ----------------
    bit    m_loading = 0;
    bit    m_keyok   = 0;
    bit    m_err     = 0;
    int    m_pos     = -1;   // replay position, -1 when idle
    rkey_t m_out     = '0;
    rkey_t m_got [$];
    rkey_t m_tab [0:NR];
    bit    m_rdy;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_loading = 0; m_keyok = 0; m_err = 0; m_pos = -1; m_out = '0;
            m_got.delete();
        end else begin
            m_rdy = !m_loading && (m_pos < 0) && kx_kt_rdy;
            if (rd_start && m_keyok) begin
                m_pos = NR;
                m_out = m_tab[NR];
            end else if (rd_next && m_pos >= 0) begin
                m_pos--;
                if (m_pos >= 0) m_out = m_tab[m_pos];
            end
            if (key_in_vld && m_rdy) begin
                m_got.delete();
                m_got.push_back(kx_rkey);
                m_loading = 1;
                m_keyok   = 0;
            end else if (m_loading) begin
                if (!kx_rkey_vld) begin
                    m_err = 1; m_loading = 0;
                end else begin
                    m_got.push_back(kx_rkey);
                    if (kx_rkey_last || m_got.size() == NR + 1) begin
                        m_loading = 0;
                        if (kx_rkey_last && m_got.size() == NR + 1) begin
                            foreach (m_tab[r]) m_tab[r] = m_got[r];
                            m_keyok = 1;
                        end else begin
                            m_err = 1;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("key_ok", key_ok, m_keyok);
        chk("kx_err", kx_err, m_err);
        chk("rk_out_vld", rk_out_vld, m_pos >= 0);
        chk("rk_out_last", rk_out_last, m_pos == 0);
        chk("rk_out", rk_out, m_out);
        if (m_pos >= 0) chk("rk_idx", rk_idx, m_pos);
        chk("key_in_rdy", key_in_rdy, !m_loading && (m_pos < 0) && kx_kt_rdy);
        chk("kx_kt_vld", kx_kt_vld, key_in_vld && !m_loading && (m_pos < 0) && kx_kt_rdy);
        chk("kx_kt", kx_kt, key_in);
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_start();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    task automatic pulse_next();
        rd_next = 1'b1;
        @(negedge clk);
        rd_next = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_key_ok"}, key_ok, 0);
        chk({tag, "_rk_out"}, rk_out, 0);
        chk({tag, "_rk_idx"}, rk_idx, 0);
        chk({tag, "_rk_out_vld"}, rk_out_vld, 0);
        chk({tag, "_rk_out_last"}, rk_out_last, 0);
        chk({tag, "_kx_err"}, kx_err, 0);
        chk({tag, "_kx_kt_vld"}, kx_kt_vld, 0);
    endtask

    // Returns edges from accept until key_ok (or a fresh error) is seen.
    task automatic load_key(input rkey_t k, input int mode, input bit mid_start, output int lat);
        bit err_before;
        err_before = kx_err;
        exp_mode   = mode;
        key_in     = k;
        key_in_vld = 1'b1;
        @(negedge clk);
        key_in_vld = 1'b0;
        lat = 1;
        while (!key_ok && !(kx_err && !err_before) && lat < 40) begin
            if (mid_start && lat == 5) rd_start = 1'b1;
            @(negedge clk);
            rd_start = 1'b0;
            lat++;
        end
        chk("load_bound", lat < 40, 1);
    endtask

    initial begin
        int lat;
        build_sbox();
        chk("model_r1", expand_rk(K_A, 1), R1_A);
        chk("model_r10", expand_rk(K_A, 10), R10_A);

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;

        pulse_start();
        chk("start_no_key", rk_out_vld, 0);

        load_key(K_A, 0, 1'b1, lat);
        chk("load_latency", lat, 11);
        chk("load_err", kx_err, 0);
        chk("start_in_load", rk_out_vld, 0);

        pulse_start();
        chk("r10_idx", rk_idx, 10);
        chk("r10_key", rk_out, R10_A);
        chk("r10_last", rk_out_last, 0);
        for (int i = 9; i >= 1; i--) pulse_next();
        chk("r1_idx", rk_idx, 1);
        chk("r1_key", rk_out, R1_A);
        chk("r1_last", rk_out_last, 0);
        pulse_next();
        chk("r0_key", rk_out, K_A);
        chk("r0_last", rk_out_last, 1);
        pulse_next();
        chk("end_vld", rk_out_vld, 0);

        pulse_start();
        repeat (6) pulse_next();
        chk("mid_idx", rk_idx, 4);
        pulse_start();
        chk("restart_idx", rk_idx, 10);
        chk("restart_key", rk_out, R10_A);

        // New key offered while the replay is still running.
        key_in = K_B; key_in_vld = 1'b1; exp_mode = 0;
        #1;
        chk("hold_rdy", key_in_rdy, 0);
        chk("hold_kt_vld", kx_kt_vld, 0);
        for (int i = 0; i < 10; i++) begin
            pulse_next();
            chk("hold_kt_vld_loop", kx_kt_vld, 0);
        end
        pulse_next();
        chk("release_kt_vld", kx_kt_vld, 1);
        @(negedge clk);
        key_in_vld = 1'b0;
        lat = 1;
        while (!key_ok && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("reload_latency", lat, 11);
        pulse_start();
        chk("keyB_r10", rk_out, R10_B);

        do_reset();
        load_key(K_A, 1, 1'b0, lat);
        chk("drop_err", kx_err, 1);
        chk("drop_key_ok", key_ok, 0);
        pulse_start();
        chk("drop_start", rk_out_vld, 0);
        load_key(K_A, 0, 1'b0, lat);
        chk("sticky_err", kx_err, 1);
        chk("sticky_key_ok", key_ok, 1);

        do_reset();
        chk("err_cleared", kx_err, 0);
        load_key(K_B, 2, 1'b0, lat);
        chk("early_last_err", kx_err, 1);
        chk("early_last_key_ok", key_ok, 0);

        // Reset in the middle of a load.
        exp_mode = 0; key_in = K_A; key_in_vld = 1'b1;
        @(negedge clk);
        key_in_vld = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        chk_reset("rst_load");
        load_key(K_A, 0, 1'b0, lat);
        chk("after_rst_latency", lat, 11);

        // Reset in the middle of a replay.
        pulse_start();
        repeat (3) pulse_next();
        chk("pre_rst_idx", rk_idx, 7);
        do_reset();
        chk_reset("rst_replay");
        load_key(K_B, 0, 1'b0, lat);
        chk("final_latency", lat, 11);
        pulse_start();
        chk("final_r10", rk_out, R10_B);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rkey_store_ctrl.md
Name: rkey_store_ctrl

Overview:
Sequencer and round-key store between a key source and the 128-bit key expander, feeding the AES decryption rounds.
- Hands a new cipher key to the expander and captures its 11-roundkey stream into an 11x128 table.
- Replays the table in reverse order (round 10 down to round 0) on demand, once per decrypted block.
- Decryption runs from the stored keys, so the expander is used once per key change, not once per block.

Parameters:
NR, 10, number of rounds; the table holds NR+1 entries
IW, 4, width of the round index (ceil(log2(NR+1)))

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
key_in  in  [0:127]  new cipher key, bit 0 = MSB of byte 0
key_in_vld  in  1  new key offered
key_in_rdy  out  1  new key accepted in cycles where key_in_vld && key_in_rdy
kx_kt  out  [0:127]  key to expander
kx_kt_vld  out  1  key valid to expander
kx_kt_rdy  in  1  expander idle and able to take a key
kx_rkey  in  [0:127]  roundkey from expander
kx_rkey_vld  in  1  kx_rkey valid this cycle
kx_rkey_last  in  1  final roundkey (round NR)
key_ok  out  1  table holds a complete schedule
rd_start  in  1  pulse: begin a reverse replay
rd_next  in  1  pulse: advance the replay
rk_out  out  [0:127]  registered roundkey
rk_idx  out  [0:IW-1]  round index of rk_out
rk_out_vld  out  1  rk_out valid
rk_out_last  out  1  rk_out is round 0
kx_err  out  1  sticky: malformed expander stream

Behaviour:
- Reset values: key_ok=0, rk_out=0, rk_idx=0, rk_out_vld=0, rk_out_last=0, kx_err=0, kx_kt_vld=0. State = EMPTY, write pointer wr_ptr=0, replay inactive.
- rst mid-load or mid-replay: returns to EMPTY and the table is treated as invalid. The expander shares rst.
- Load-side states:
  - EMPTY: no valid schedule.
  - LOAD: capturing roundkeys.
  - READY: schedule complete.
- key_in_rdy = (state != LOAD) && !replay_active && kx_kt_rdy.
- Pass-through to expander: kx_kt = key_in, kx_kt_vld = key_in_vld && key_in_rdy (combinational).
- Accept cycle (key_in_vld && key_in_rdy):
  - The expander presents kt on rkey in the same cycle with kx_rkey_vld=1.
  - Write table[0] = kx_rkey; set wr_ptr=1, key_ok=0, state=LOAD.
- LOAD, each cycle with kx_rkey_vld: write table[wr_ptr], then wr_ptr++.
- LOAD ends when kx_rkey_vld && kx_rkey_last. That entry is written and state goes to READY with key_ok=1 on the next cycle.
- Stream checks (kx_err):
  - If kx_rkey_last arrives with wr_ptr != NR, set kx_err, go to EMPTY, key_ok=0.
  - If kx_rkey_vld drops during LOAD, set kx_err, go to EMPTY, key_ok=0.
  - Load latency: NR+1 cycles from accept to key_ok=1 (11 for NR=10).
- kx_rkey_vld outside LOAD and outside the accept cycle is ignored.
- Replay, starting:
  - rd_start while key_ok=1: the next cycle gives rk_out=table[NR], rk_idx=NR, rk_out_vld=1. The replay becomes active.
  - rd_start while key_ok=0: ignored; rk_out_vld stays 0.
  - rd_start during an active replay restarts at NR (takes priority over rd_next).
- Replay, advancing:
  - rd_next while active and rk_idx>0: the next cycle gives rk_idx-1 and the matching entry. Read latency is 1 cycle.
  - rk_out_last = rk_out_vld && rk_idx==0.
  - rd_next while rk_idx==0: rk_out_vld=0 on the next cycle and the replay ends (no wrap).
  - rd_next while inactive: ignored.
  - Without rd_next, rk_out holds its value.
- A new key cannot be accepted while a replay is active (key_in_rdy=0). A replay cannot start during LOAD (key_ok=0).
- The table may map to registers or single-port-read RAM. The read is registered, and only the output register drives rk_out.

Decomposition:
- Package aes_dec_pkg:
  - constants NR_128=10, RK_W=128
  - typedef rkey_t (logic [0:127])
  - typedef ld_state_t enum {EMPTY, LOAD, READY}
- One sub-module, rkey_table: (NR+1)x128 storage with one write port, one registered read port, and index inputs.
- The FSM and replay counter stay in rkey_store_ctrl.

Test Plan:
- Load FIPS-197 Appendix A key 2b7e151628aed2a6abf7158809cf4f3c with the real expander -> key_in_rdy drops for 11 cycles, then key_ok=1 and kx_err=0.
- rd_start, then 10 rd_next -> rk_out in order:
  - idx10 d014f9a8c9ee2589e13f0cc8b6630ca6
  - idx1 a0fafe1788542cb123a339392a6c7605
  - idx0 2b7e151628aed2a6abf7158809cf4f3c, with rk_out_last=1 only there
  - an 11th rd_next -> rk_out_vld=0
- rd_start issued before any key and during LOAD -> rk_out_vld stays 0. rd_start at idx 4 -> next cycle idx 10 with the round-10 key.
- key_in_vld held high during an active replay -> key_in_rdy=0 and kx_kt_vld=0 until the replay ends. The key is then accepted and key_ok drops for 11 cycles.
- Stub expander drops kx_rkey_vld after 5 keys, and separately asserts kx_rkey_last at wr_ptr=7 -> kx_err=1 (sticky), key_ok=0, state EMPTY.
- rst asserted mid-LOAD and mid-replay -> next cycle all outputs at reset values. A following key load completes normally.
